sra_seq_ctrl: RTL and testbench



---
 rtl/sra_pkg.sv | 11 +
 rtl/sra_seq_ctrl_au2.sv | 12 +
 rtl/sra_seq_ctrl.sv | 88 ++++++++
 tb/tb_sra_seq_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sra_pkg.sv
// sra_pkg: shared constants, AU2 control codes and sequencer state encoding.
package sra_pkg;
    localparam int MSB = 15;
    localparam logic [1:0] AU_SUB = 2'b00;
    localparam logic [1:0] AU_ADD = 2'b01;
    localparam logic [1:0] AU_MAX = 2'b10;
    typedef enum logic [3:0] {
        S_IDLE, S_OP1, S_OP2, S_OP3, S_OP4, S_OP5,
        S_OP6, S_OP7, S_OP8, S_OP9, S_OP10
    } state_t;
endpackage

// File: rtl/sra_seq_ctrl_au2.sv
// sra_seq_ctrl_au2: shared arithmetic unit, ctrl 00 = A-B, 01 = A+B, 1x = max(A,B).
module sra_seq_ctrl_au2 #(
    parameter int msb = 15
) (
    input  logic [1:0]            i_ctrl,
    input  logic signed [msb:0]   i_a,
    input  logic signed [msb:0]   i_b,
    output logic signed [msb:0]   o_y
);
    always_comb
        o_y = i_ctrl[1] ? ((i_a > i_b) ? i_a : i_b) : i_ctrl[0] ? i_a + i_b : i_a - i_b;
endmodule

// File: rtl/sra_seq_ctrl.sv
// sra_seq_ctrl: sequences z ~= max(x, x - x/8 + y/2) through a single shared AU2,
// one operation per cycle, with a start/busy/done handshake.
module sra_seq_ctrl
    import sra_pkg::*;
#(
    parameter int msb = MSB
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [msb:0] in_a,
    input  logic signed [msb:0] in_b,
    output logic                busy,
    output logic                done,
    output logic signed [msb:0] out_z
);
    localparam logic signed [msb:0] MOST_NEG = {1'b1, {msb{1'b0}}};
    localparam logic signed [msb:0] SAT_NEG  = {1'b1, {(msb-1){1'b0}}, 1'b1};
    state_t              r_state;
    logic signed [msb:0] r_ra, r_rb, r_t, r_pa, r_pb, r_x, r_y;
    logic signed [msb:0] w_a, w_b, w_y;
    logic [1:0]          w_ctrl;
    // Operand routing per state; the >>> shifts are pure wiring into the AU.
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_ctrl = AU_SUB;
        case (r_state)
            S_OP1:   begin w_b = r_ra; end
            S_OP2:   begin w_a = r_ra; w_b = r_t;  w_ctrl = AU_MAX; end
            S_OP3:   begin w_b = r_rb; end
            S_OP4:   begin w_a = r_rb; w_b = r_t;  w_ctrl = AU_MAX; end
            S_OP5:   begin w_a = r_pa; w_b = r_pb; w_ctrl = AU_MAX; end
            S_OP6:   begin w_a = r_pa; w_b = r_pb; w_ctrl = AU_ADD; end
            S_OP7:   begin w_a = r_y;  w_b = r_x; end
            S_OP8:   begin w_a = r_x;  w_b = r_x >>> 3; end
            S_OP9:   begin w_a = r_t;  w_b = r_y >>> 1; w_ctrl = AU_ADD; end
            S_OP10:  begin w_a = r_x;  w_b = r_t;  w_ctrl = AU_MAX; end
            default: ;
        endcase
    end
    sra_seq_ctrl_au2 #(.msb(msb)) u_au2 (
        .i_ctrl (w_ctrl),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_y    (w_y)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            out_z   <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_t     <= '0;
            r_pa    <= '0;
            r_pb    <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_ra    <= (in_a == MOST_NEG) ? SAT_NEG : in_a;
                    r_rb    <= (in_b == MOST_NEG) ? SAT_NEG : in_b;
                    busy    <= 1'b1;
                    r_state <= S_OP1;
                end
            end else begin
                r_state <= (r_state == S_OP10) ? S_IDLE : state_t'(r_state + 4'd1);
                case (r_state)
                    S_OP1, S_OP3, S_OP8, S_OP9: r_t  <= w_y;
                    S_OP2:                      r_pa <= w_y;
                    S_OP4:                      r_pb <= w_y;
                    S_OP5:                      r_x  <= w_y;
                    S_OP6, S_OP7:               r_y  <= w_y;
                    S_OP10: begin
                        out_z <= w_y;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sra_seq_ctrl.sv
// tb_sra_seq_ctrl: directed vectors with hand-computed results for sra_seq_ctrl.
module tb_sra_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        busy, done;
    logic [15:0] out_z;
    logic [15:0] last_z = '0;
    logic        saw_done;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sra_seq_ctrl #(.msb(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .out_z (out_z)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Start a job at edge k, expect busy through k+9 and done/out_z at k+10.
    // pulse_at: an extra start pulse before edge k+pulse_at with inputs 1,1.
    // hold: keep start high and present na/nb for a follow-on job.
    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                           input int pulse_at, input logic hold,
                           input logic [15:0] na, input logic [15:0] nb);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        step;
        chk1("accept_busy", busy, 1'b1);
        chk1("accept_done", done, 1'b0);
        chk("accept_z_hold", out_z, last_z);
        if (hold) begin
            in_a = na;
            in_b = nb;
        end else begin
            start = 1'b0;
            in_a  = 16'hdead;
            in_b  = 16'hbeef;
        end
        for (int i = 1; i < 10; i++) begin
            if (pulse_at != 0 && i == pulse_at) begin
                start = 1'b1;
                in_a  = 16'd1;
                in_b  = 16'd1;
            end
            step;
            if (!hold) start = 1'b0;
            chk1("inflight_busy", busy, 1'b1);
            chk1("inflight_done", done, 1'b0);
        end
        step;
        chk1("final_done", done, 1'b1);
        chk1("final_busy", busy, 1'b0);
        chk("final_z", out_z, exp);
        last_z = exp;
    endtask

    initial begin
        repeat (2) step;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_z", out_z, 16'd0);
        rst_n = 1'b1;
        repeat (2) step;
        chk1("idle_busy", busy, 1'b0);

        run_job(16'd3, 16'd4, 16'd5, 0, 1'b0, 16'd0, 16'd0);
        step;
        chk1("done_pulse_end", done, 1'b0);
        chk("z_holds", out_z, 16'd5);

        run_job(16'hff9c, 16'd0, 16'd100, 0, 1'b0, 16'd0, 16'd0);
        run_job(16'h8000, 16'h8000, 16'd32767, 0, 1'b0, 16'd0, 16'd0);

        run_job(16'd8, 16'd8, 16'd11, 3, 1'b0, 16'd0, 16'd0);
        saw_done = 1'b0;
        repeat (12) begin
            step;
            if (done) saw_done = 1'b1;
        end
        chk1("ignored_start_no_done", saw_done, 1'b0);
        chk("ignored_start_z", out_z, 16'd11);

        run_job(16'd3, 16'd4, 16'd5, 0, 1'b1, 16'd6, 16'd8);
        run_job(16'd6, 16'd8, 16'd10, 0, 1'b0, 16'd0, 16'd0);

        in_a  = 16'd8;
        in_b  = 16'd8;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (5) step;
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk("abort_z", out_z, 16'd0);
        last_z = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            step;
            if (done) saw_done = 1'b1;
        end
        chk1("abort_no_done", saw_done, 1'b0);
        run_job(16'd3, 16'd4, 16'd5, 0, 1'b0, 16'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
